// File: rtl/video_pointer_ctrl.sv
// Hardware pointer overlay: double-buffered position registers, hit test, sprite RAM arbiter.
// Hotspot offset is built only when VIDEO_POINTER_HOTSPOT_EN is defined.
module video_pointer_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        visible,
  input  logic        frame_start,
  input  logic        reg_wr,
  input  logic [1:0]  reg_addr,
  input  logic [15:0] reg_wdata,
  output logic [15:0] reg_rdata,
  input  logic        spr_req,
  input  logic [9:0]  spr_addr,
  input  logic [12:0] spr_wdata,
  output logic        spr_ack,
  output logic [9:0]  ram_addr,
  output logic        ram_we,
  output logic [12:0] ram_wdata,
  output logic [4:0]  pointer_x,
  output logic [4:0]  pointer_y,
  output logic        pointer_active
);

  typedef enum logic {VIDEO, CPU} arb_t;

  logic [15:0] pos_x_p, pos_y_p, pos_x_l, pos_y_l;
  logic [15:0] pos_x_n, pos_y_n;
  logic        en_p, en_l, en_n;
  logic [4:0]  hx_p, hy_p, hx_l, hy_l, hx_n, hy_n;
  logic [15:0] rd_n;
  logic [15:0] ex, ey, dx, dy;
  logic        hit;
  logic        armed;
  arb_t        state;

  always_comb begin
    pos_x_n = pos_x_p;
    pos_y_n = pos_y_p;
    en_n    = en_p;
    hx_n    = hx_p;
    hy_n    = hy_p;
    if (reg_wr) begin
      unique case (reg_addr)
        2'd0: pos_x_n = reg_wdata;
        2'd1: pos_y_n = reg_wdata;
        2'd2: en_n    = reg_wdata[0];
        2'd3: begin
`ifdef VIDEO_POINTER_HOTSPOT_EN
          hx_n = reg_wdata[4:0];
          hy_n = reg_wdata[12:8];
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_n = '0;
    unique case (reg_addr)
      2'd0: rd_n = pos_x_p;
      2'd1: rd_n = pos_y_p;
      2'd2: rd_n = {15'd0, en_p};
      2'd3: rd_n = {3'd0, hy_p, 3'd0, hx_p};
      default: rd_n = '0;
    endcase
  end

  // Modulo-2^16 differences make a pointer clipped at left/top still hit.
  assign ex  = pos_x_l - {11'd0, hx_l};
  assign ey  = pos_y_l - {11'd0, hy_l};
  assign dx  = x - ex;
  assign dy  = y - ey;
  assign hit = visible & en_l & (dx[15:5] == '0) & (dy[15:5] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_p        <= '0;
      pos_y_p        <= '0;
      en_p           <= 1'b0;
      hx_p           <= '0;
      hy_p           <= '0;
      pos_x_l        <= '0;
      pos_y_l        <= '0;
      en_l           <= 1'b0;
      hx_l           <= '0;
      hy_l           <= '0;
      reg_rdata      <= '0;
      pointer_active <= 1'b0;
      pointer_x      <= '0;
      pointer_y      <= '0;
      armed          <= 1'b0;
    end else begin
      pos_x_p        <= pos_x_n;
      pos_y_p        <= pos_y_n;
      en_p           <= en_n;
      hx_p           <= hx_n;
      hy_p           <= hy_n;
      if (frame_start) begin
        pos_x_l <= pos_x_n;
        pos_y_l <= pos_y_n;
        en_l    <= en_n;
        hx_l    <= hx_n;
        hy_l    <= hy_n;
      end
      reg_rdata      <= rd_n;
      pointer_active <= hit;
      if (hit) begin
        pointer_x <= dx[4:0];
        pointer_y <= dy[4:0];
      end
      armed          <= 1'b1;
    end
  end

  // armed drops asynchronously, so a pending CPU write is never acked in reset.
  assign state = pointer_active ? VIDEO : CPU;

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    spr_ack   = 1'b0;
    unique case (state)
      VIDEO: ram_addr = {pointer_y, pointer_x};
      CPU: begin
        if (spr_req && armed) begin
          ram_addr  = spr_addr;
          ram_wdata = spr_wdata;
          ram_we    = 1'b1;
          spr_ack   = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_video_pointer_ctrl.sv
// Directed bench for video_pointer_ctrl: register buffering, hit test,
// RAM arbitration and reset abort; hotspot checks follow VIDEO_POINTER_HOTSPOT_EN.
module tb_video_pointer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] x, y;
  logic        visible, frame_start;
  logic        reg_wr;
  logic [1:0]  reg_addr;
  logic [15:0] reg_wdata, reg_rdata;
  logic        spr_req;
  logic [9:0]  spr_addr;
  logic [12:0] spr_wdata;
  logic        spr_ack;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [12:0] ram_wdata;
  logic [4:0]  pointer_x, pointer_y;
  logic        pointer_active;

  int vectors = 0;
  int miscompares = 0;

  video_pointer_ctrl dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .visible(visible),
    .frame_start(frame_start), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .spr_req(spr_req),
    .spr_addr(spr_addr), .spr_wdata(spr_wdata), .spr_ack(spr_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .pointer_x(pointer_x), .pointer_y(pointer_y),
    .pointer_active(pointer_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    reg_wr = 1'b1;
    reg_addr = a;
    reg_wdata = d;
    @(negedge clk);
    reg_wr = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_act"}, {31'd0, pointer_active}, 0);
    chk({tag, "_px"}, {27'd0, pointer_x}, 0);
    chk({tag, "_py"}, {27'd0, pointer_y}, 0);
    chk({tag, "_ack"}, {31'd0, spr_ack}, 0);
    chk({tag, "_we"}, {31'd0, ram_we}, 0);
    chk({tag, "_ra"}, {22'd0, ram_addr}, 0);
    chk({tag, "_rd"}, {16'd0, reg_rdata}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    x = 0; y = 50; visible = 1'b1; frame_start = 1'b0;
    reg_wr = 1'b0; reg_addr = 0; reg_wdata = 0;
    spr_req = 1'b0; spr_addr = 0; spr_wdata = 0;
    #3;
    all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic pointer at (100,50)
    wr(2'd0, 16'd100);
    wr(2'd1, 16'd50);
    wr(2'd2, 16'd1);
    frame();
    for (int i = 0; i < 32; i++) begin
      x = 16'(100 + i);
      @(negedge clk);
      chk("row_act", {31'd0, pointer_active}, 1);
      chk("row_px", {27'd0, pointer_x}, i);
      chk("row_py", {27'd0, pointer_y}, 0);
    end
    x = 16'd132;
    @(negedge clk);
    chk("x132_act", {31'd0, pointer_active}, 0);
    chk("x132_hold", {27'd0, pointer_x}, 31);
    chk("idle_we", {31'd0, ram_we}, 0);
    chk("idle_ra", {22'd0, ram_addr}, 0);

    // mid-frame write stays pending
    wr(2'd0, 16'd200);
    reg_addr = 2'd0;
    x = 16'd100;
    @(negedge clk);
    chk("pend_rd", {16'd0, reg_rdata}, 200);
    chk("pend_old_act", {31'd0, pointer_active}, 1);
    chk("pend_old_px", {27'd0, pointer_x}, 0);
    x = 16'd205;
    @(negedge clk);
    chk("pend_new_off", {31'd0, pointer_active}, 0);
    frame();
    x = 16'd205;
    @(negedge clk);
    chk("live_act", {31'd0, pointer_active}, 1);
    chk("live_px", {27'd0, pointer_x}, 5);
    reg_addr = 2'd2;
    @(negedge clk);
    chk("ctrl_rd", {16'd0, reg_rdata}, 1);

    // CPU write blocked while video owns the RAM
    spr_req = 1'b1;
    spr_addr = 10'h155;
    spr_wdata = 13'h1abc;
    for (int i = 0; i < 10; i++) begin
      x = 16'(200 + i);
      @(negedge clk);
      chk("blk_act", {31'd0, pointer_active}, 1);
      chk("blk_ack", {31'd0, spr_ack}, 0);
      chk("blk_we", {31'd0, ram_we}, 0);
      chk("blk_ra", {22'd0, ram_addr}, i);
    end
    x = 16'd0;
    @(negedge clk);
    chk("cpu_ack", {31'd0, spr_ack}, 1);
    chk("cpu_we", {31'd0, ram_we}, 1);
    chk("cpu_ra", {22'd0, ram_addr}, 32'h155);
    chk("cpu_wd", {19'd0, ram_wdata}, 32'h1abc);
    spr_req = 1'b0;
    #1;
    chk("cpu_ack_drop", {31'd0, spr_ack}, 0);
    @(negedge clk);

    // hotspot: POS_X=2, hot_x=5
    wr(2'd0, 16'd2);
    wr(2'd3, 16'h0005);
    reg_addr = 2'd3;
    frame();
`ifdef VIDEO_POINTER_HOTSPOT_EN
    chk("hot_rd", {16'd0, reg_rdata}, 5);
    x = 16'd0;
    @(negedge clk);
    chk("hot_act", {31'd0, pointer_active}, 1);
    chk("hot_px", {27'd0, pointer_x}, 3);
    x = 16'd28;
    @(negedge clk);
    chk("hot_x28", {27'd0, pointer_x}, 31);
`else
    chk("nohot_rd", {16'd0, reg_rdata}, 0);
    x = 16'd0;
    @(negedge clk);
    chk("nohot_x0", {31'd0, pointer_active}, 0);
    x = 16'd1;
    @(negedge clk);
    chk("nohot_x1", {31'd0, pointer_active}, 0);
    x = 16'd32;
    @(negedge clk);
    chk("nohot_act", {31'd0, pointer_active}, 1);
    chk("nohot_px", {27'd0, pointer_x}, 30);
`endif

    // reset mid-line with a CPU request pending
    x = 16'd10;
    @(negedge clk);
    chk("pre_rst_act", {31'd0, pointer_active}, 1);
    x = 16'd100;
    spr_req = 1'b1;
    spr_addr = 10'h2aa;
    #2;
    rst_n = 1'b0;
    #1;
    all_zero("midrst");
    @(negedge clk);
    all_zero("midrst_hold");
    spr_req = 1'b0;
    rst_n = 1'b1;
    reg_addr = 2'd2;
    x = 16'd5;
    y = 16'd3;
    @(negedge clk);
    chk("post_ctrl", {16'd0, reg_rdata}, 0);
    chk("post_act0", {31'd0, pointer_active}, 0);
    frame();
    chk("post_act1", {31'd0, pointer_active}, 0);
    wr(2'd2, 16'd1);
    @(negedge clk);
    chk("post_act2", {31'd0, pointer_active}, 0);
    frame();
    @(negedge clk);
    chk("post_act3", {31'd0, pointer_active}, 1);
    chk("post_px", {27'd0, pointer_x}, 5);
    chk("post_py", {27'd0, pointer_y}, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
